// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch PC controller: owns the word-addressed PC, runs the request/ready
// handshake to instruction memory, fills IF/ID and flushes younger stages on redirects.
module fetch_pc_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_true,
    input  logic [ADDR_W-1:0] new_addr,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_rdy,
    input  logic [DATA_W-1:0] im_data,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic              flush,
    output logic [CNT_W-1:0]  redirect_cnt
);
    typedef enum logic [1:0] {BOOT, FETCH, WAIT} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, pend_addr, pend_addr_n, buf_pc, buf_pc_n, if_pc_n;
    logic [DATA_W-1:0] buf_inst, buf_inst_n, if_inst_n;
    logic              pend_v, pend_v_n, buf_v, buf_v_n, if_valid_n;
    logic [CNT_W-1:0]  cnt_n;

    // Outputs are forced low in the reset cycle, before state has been cleared.
    assign im_req  = !rst && ((state == FETCH && !stall && !buf_v) || state == WAIT);
    assign im_addr = pc;
    assign flush   = !rst && branch_true && (state != BOOT);

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pend_v_n    = pend_v;
        pend_addr_n = pend_addr;
        buf_v_n     = buf_v;
        buf_pc_n    = buf_pc;
        buf_inst_n  = buf_inst;
        if_valid_n  = if_valid;
        if_pc_n     = if_pc;
        if_inst_n   = if_inst;
        cnt_n       = redirect_cnt;
        case (state)
            BOOT: state_n = FETCH;
            FETCH: begin
                if (branch_true) begin
                    pc_n       = new_addr;
                    if_valid_n = 1'b0;
                    buf_v_n    = 1'b0;
                    cnt_n      = redirect_cnt + 1'b1;
                end else if (!stall) begin
                    if (buf_v) begin
                        if_valid_n = 1'b1;
                        if_pc_n    = buf_pc;
                        if_inst_n  = buf_inst;
                        buf_v_n    = 1'b0;
                    end else if (im_rdy) begin
                        if_valid_n = 1'b1;
                        if_pc_n    = pc;
                        if_inst_n  = im_data;
                        pc_n       = pc + 1'b1;
                    end else begin
                        if_valid_n = 1'b0;
                        state_n    = WAIT;
                    end
                end
            end
            WAIT: begin
                if (branch_true) begin
                    pend_v_n    = 1'b1;
                    pend_addr_n = new_addr;
                    if_valid_n  = 1'b0;
                    cnt_n       = redirect_cnt + 1'b1;
                end
                if (im_rdy) begin
                    state_n = FETCH;
                    // The outstanding word belongs to the old path whenever a redirect is known.
                    if (branch_true || pend_v) begin
                        pc_n       = branch_true ? new_addr : pend_addr;
                        pend_v_n   = 1'b0;
                        if_valid_n = 1'b0;
                    end else if (stall) begin
                        buf_v_n    = 1'b1;
                        buf_pc_n   = pc;
                        buf_inst_n = im_data;
                        pc_n       = pc + 1'b1;
                    end else begin
                        if_valid_n = 1'b1;
                        if_pc_n    = pc;
                        if_inst_n  = im_data;
                        pc_n       = pc + 1'b1;
                    end
                end else if (!stall) begin
                    if_valid_n = 1'b0;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            pend_v       <= 1'b0;
            pend_addr    <= '0;
            buf_v        <= 1'b0;
            buf_pc       <= '0;
            buf_inst     <= '0;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_inst      <= '0;
            redirect_cnt <= '0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            pend_v       <= pend_v_n;
            pend_addr    <= pend_addr_n;
            buf_v        <= buf_v_n;
            buf_pc       <= buf_pc_n;
            buf_inst     <= buf_inst_n;
            if_valid     <= if_valid_n;
            if_pc        <= if_pc_n;
            if_inst      <= if_inst_n;
            redirect_cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: a per-cycle reference model checked every cycle, directed
// scenarios with literal expectations, and a short pseudo-random soak.
module tb_fetch_pc_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1, stall = 1'b0, branch_true = 1'b0, im_rdy = 1'b0;
    logic [31:0] new_addr = '0, im_data;
    logic        im_req, if_valid, flush, im_req1, if_valid1, flush1;
    logic [31:0] im_addr, if_pc, if_inst, im_addr1, if_pc1, if_inst1;
    logic [15:0] redirect_cnt, redirect_cnt1;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
    endfunction

    assign im_data = mem(im_addr);

    fetch_pc_ctrl u_dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_true(branch_true), .new_addr(new_addr),
        .im_req(im_req), .im_addr(im_addr), .im_rdy(im_rdy), .im_data(im_data),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .flush(flush),
        .redirect_cnt(redirect_cnt)
    );

    fetch_pc_ctrl #(.RESET_PC(32'hFFFF_FFFF)) u_top (
        .clk(clk), .rst(rst), .stall(stall), .branch_true(branch_true), .new_addr(new_addr),
        .im_req(im_req1), .im_addr(im_addr1), .im_rdy(im_rdy), .im_data(im_data),
        .if_valid(if_valid1), .if_pc(if_pc1), .if_inst(if_inst1), .flush(flush1),
        .redirect_cnt(redirect_cnt1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase flags plus the architectural registers.
    bit          m_live = 0, m_boot, m_wait, m_pend, m_buf, m_v;
    logic [31:0] m_pc, m_tgt, m_bpc, m_binst, m_ipc, m_iinst;
    logic [15:0] m_cnt;

    always @(posedge clk) begin
        logic [31:0] tgt;
        bit          redir;
        if (rst) begin
            m_live = 1; m_boot = 1; m_wait = 0; m_pend = 0; m_buf = 0; m_v = 0;
            m_pc = 32'h0; m_ipc = 0; m_iinst = 0; m_cnt = 0;
        end else if (!m_live) begin
        end else if (m_boot) begin
            m_boot = 0;
        end else if (!m_wait) begin
            if (branch_true) begin
                m_pc = new_addr; m_v = 0; m_buf = 0; m_cnt = m_cnt + 16'd1;
            end else if (!stall) begin
                if (m_buf) begin
                    m_v = 1; m_ipc = m_bpc; m_iinst = m_binst; m_buf = 0;
                end else if (im_rdy) begin
                    m_v = 1; m_ipc = m_pc; m_iinst = im_data; m_pc = m_pc + 32'd1;
                end else begin
                    m_v = 0; m_wait = 1;
                end
            end
        end else begin
            redir = branch_true || m_pend;
            tgt   = branch_true ? new_addr : m_tgt;
            if (branch_true) begin
                m_cnt = m_cnt + 16'd1; m_v = 0; m_pend = 1; m_tgt = new_addr;
            end
            if (im_rdy) begin
                m_wait = 0;
                if (redir) begin
                    m_pc = tgt; m_pend = 0;
                end else if (stall) begin
                    m_buf = 1; m_bpc = m_pc; m_binst = im_data; m_pc = m_pc + 32'd1;
                end else begin
                    m_v = 1; m_ipc = m_pc; m_iinst = im_data; m_pc = m_pc + 32'd1;
                end
            end else if (!stall) begin
                m_v = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("im_req", {31'b0, im_req},
                {31'b0, !rst && ((!m_boot && !m_wait && !stall && !m_buf) || m_wait)});
            chk("im_addr", im_addr, m_pc);
            chk("flush", {31'b0, flush}, {31'b0, !rst && branch_true && !m_boot});
            chk("if_valid", {31'b0, if_valid}, {31'b0, m_v});
            chk("redirect_cnt", {16'b0, redirect_cnt}, {16'b0, m_cnt});
            if (m_v) begin
                chk("if_pc", if_pc, m_ipc);
                chk("if_inst", if_inst, m_iinst);
            end
        end
    end

    task automatic drive(input bit r, input bit rdy, input bit br, input logic [31:0] na,
                         input bit st);
        @(posedge clk); #1;
        rst = r; im_rdy = rdy; branch_true = br; new_addr = na; stall = st;
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_cnt", {16'b0, redirect_cnt}, 32'd0);
        chk("rst_im_addr", im_addr, 32'd0);
        drive(1, 0, 1, 32'h55, 0);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_im_req", {31'b0, im_req}, 32'd0);
        // Streaming fetch with zero wait states
        drive(0, 1, 0, 0, 0);
        chk("boot_im_req", {31'b0, im_req}, 32'd0);
        drive(0, 1, 0, 0, 0);
        chk("fetch_im_req", {31'b0, im_req}, 32'd1);
        chk("hi_im_addr", im_addr1, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 0);
            chk("seq_if_pc", if_pc, i);
            chk("seq_if_valid", {31'b0, if_valid}, 32'd1);
            if (i == 0) chk("wrap_if_pc0", if_pc1, 32'hFFFF_FFFF);
            if (i == 1) chk("wrap_if_pc1", if_pc1, 32'h0);
        end
        // Redirect in FETCH
        drive(0, 1, 1, 32'h40, 0);
        chk("br_flush", {31'b0, flush}, 32'd1);
        chk("br_pc5", im_addr, 32'd5);
        drive(0, 1, 0, 0, 0);
        chk("br_im_addr", im_addr, 32'h40);
        chk("br_bubble", {31'b0, if_valid}, 32'd0);
        drive(0, 1, 1, 32'h8, 0);
        chk("br_if_pc", if_pc, 32'h40);
        chk("br_cnt", {16'b0, redirect_cnt}, 32'd1);
        // Redirect while a fetch is outstanding
        drive(0, 0, 0, 0, 0);
        chk("w_addr0", im_addr, 32'h8);
        drive(0, 0, 1, 32'h20, 0);
        chk("w_addr1", im_addr, 32'h8);
        chk("w_flush", {31'b0, flush}, 32'd1);
        drive(0, 0, 0, 0, 0);
        chk("w_addr2", im_addr, 32'h8);
        chk("w_req", {31'b0, im_req}, 32'd1);
        drive(0, 1, 0, 0, 0);
        chk("w_addr3", im_addr, 32'h8);
        chk("w_valid", {31'b0, if_valid}, 32'd0);
        drive(0, 1, 0, 0, 0);
        chk("w_target", im_addr, 32'h20);
        chk("w_discard", {31'b0, if_valid}, 32'd0);
        chk("w_cnt", {16'b0, redirect_cnt}, 32'd3);
        drive(0, 1, 1, 32'h3, 0);
        chk("w_if_pc", if_pc, 32'h20);
        chk("w_if_inst", if_inst, mem(32'h20));
        // WAIT completes under stall, word parks in the hold buffer
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        chk("s_req_wait", {31'b0, im_req}, 32'd1);
        drive(0, 1, 0, 0, 1);
        chk("s_req_stall", {31'b0, im_req}, 32'd0);
        chk("s_addr", im_addr, 32'd4);
        drive(0, 1, 0, 0, 0);
        chk("s_req_drain", {31'b0, im_req}, 32'd0);
        drive(0, 0, 0, 0, 0);
        chk("s_if_pc", if_pc, 32'd3);
        chk("s_if_inst", if_inst, mem(32'd3));
        chk("s_addr_next", im_addr, 32'd4);
        // Reset in WAIT with a ready in the same cycle
        drive(1, 1, 1, 32'h77, 0);
        chk("r_flush", {31'b0, flush}, 32'd0);
        chk("r_req", {31'b0, im_req}, 32'd0);
        drive(0, 1, 0, 0, 0);
        chk("r_boot_req", {31'b0, im_req}, 32'd0);
        chk("r_valid", {31'b0, if_valid}, 32'd0);
        chk("r_cnt", {16'b0, redirect_cnt}, 32'd0);
        drive(0, 1, 0, 0, 0);
        chk("r_addr", im_addr, 32'd0);
        drive(0, 0, 0, 0, 0);
        chk("r_if_pc", if_pc, 32'd0);
        // Pseudo-random soak against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] na;
            na = ($urandom_range(3) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(1))
                                          : 32'($urandom_range(255));
            drive($urandom_range(63) == 0, $urandom_range(1) == 1, $urandom_range(7) == 0,
                  na, $urandom_range(3) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
